vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator. Counts pixel ticks, qualified by a pixel-clock enable, over a fully configurable horizontal/vertical timing frame. It produces stage-0 pixel coordinates for the renderer, plus sync and blank outputs delayed by a configurable pipeline depth so they line up with the renderer's colour output. It also provides line/frame strobes, a frame counter and power-of-two coordinate downscaling for low-resolution framebuffers. It sits between the board clock and the VGA DAC/renderer path.

---
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Purpose: VGA raster timing generator; stage-0 coordinates/strobes plus pipelined sync/blank.
// Latency: coordinates and strobes are combinational from the counters; sync/blank lag PIPE_DEPTH pixel ticks.
// Backpressure: none; all state advances only on pix_en and holds while it is low.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int COUNT_W     = 10,
    parameter int PIPE_DEPTH  = 2,
    parameter int SCALE_SHIFT = 0,
    parameter int FRAME_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic [COUNT_W-1:0] hcount,
    output logic [COUNT_W-1:0] vcount,
    output logic [COUNT_W-1:0] xcoord,
    output logic [COUNT_W-1:0] ycoord,
    output logic [COUNT_W-1:0] xcoord_s,
    output logic [COUNT_W-1:0] ycoord_s,
    output logic               coord_valid,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               hsync,
    output logic               vsync,
    output logic               display_en,
    output logic               blank_n
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // Region boundaries: sync, back porch, active, front porch.
    localparam logic [COUNT_W-1:0] H_LAST    = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST    = COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W-1:0] H_SYNC_C  = COUNT_W'(H_SYNC);
    localparam logic [COUNT_W-1:0] V_SYNC_C  = COUNT_W'(V_SYNC);
    localparam logic [COUNT_W-1:0] H_START_C = COUNT_W'(H_SYNC + H_BP);
    localparam logic [COUNT_W-1:0] V_START_C = COUNT_W'(V_SYNC + V_BP);
    localparam logic [COUNT_W-1:0] H_END_C   = COUNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [COUNT_W-1:0] V_END_C   = COUNT_W'(V_SYNC + V_BP + V_ACTIVE);

    logic h_last;
    logic v_last;
    logic hs_int;
    logic vs_int;
    logic h_act;
    logic v_act;

    // Bit 0 is the newest sample; the last bit drives the outputs.
    // Stored at "asserted = 1" sense so reset (all zero) means inactive.
    logic [PIPE_DEPTH-1:0] hs_pipe;
    logic [PIPE_DEPTH-1:0] vs_pipe;
    logic [PIPE_DEPTH-1:0] de_pipe;

    assign h_last = (hcount == H_LAST);
    assign v_last = (vcount == V_LAST);

    // Raster counters: horizontal wraps every line, vertical steps on the horizontal wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            hcount <= h_last ? '0 : hcount + 1'b1;
            if (h_last) begin
                vcount <= v_last ? '0 : vcount + 1'b1;
            end
        end
    end

    // Completed-frame counter, bumped on the same edge both counters wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (pix_en && h_last && v_last) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Stage-0 region decode and active-area coordinates.
    always_comb begin
        hs_int      = (hcount < H_SYNC_C);
        vs_int      = (vcount < V_SYNC_C);
        h_act       = (hcount >= H_START_C) && (hcount < H_END_C);
        v_act       = (vcount >= V_START_C) && (vcount < V_END_C);
        coord_valid = h_act && v_act;
        xcoord      = coord_valid ? (hcount - H_START_C) : '0;
        ycoord      = coord_valid ? (vcount - V_START_C) : '0;
        xcoord_s    = xcoord >> SCALE_SHIFT;
        ycoord_s    = ycoord >> SCALE_SHIFT;
        line_start  = pix_en && (hcount == '0);
        frame_start = pix_en && (hcount == '0) && (vcount == '0);
    end

    // Delay line aligning sync/blank with the renderer's colour output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_pipe <= '0;
            vs_pipe <= '0;
            de_pipe <= '0;
        end else if (pix_en) begin
            hs_pipe <= PIPE_DEPTH'({hs_pipe, hs_int});
            vs_pipe <= PIPE_DEPTH'({vs_pipe, vs_int});
            de_pipe <= PIPE_DEPTH'({de_pipe, coord_valid});
        end
    end

    // Apply output polarity to the aligned sync pulses.
    always_comb begin
        hsync      = HS_POL ? hs_pipe[PIPE_DEPTH-1] : ~hs_pipe[PIPE_DEPTH-1];
        vsync      = VS_POL ? vs_pipe[PIPE_DEPTH-1] : ~vs_pipe[PIPE_DEPTH-1];
        display_en = de_pipe[PIPE_DEPTH-1];
        blank_n    = de_pipe[PIPE_DEPTH-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose: randomized scoreboard bench for vga_timing_gen against a closed-form tick-count model.
// Latency: one expected record per clk, compared on the falling edge of the same cycle.
// Backpressure: none; pix_en and reset are randomized or scripted by the driver.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
    localparam int VA = 5, VF = 1, VSW = 2, VB = 1;
    localparam int CW = 5, PD = 3, SS = 1, FW = 3;
    localparam bit HP = 1'b1, VP = 1'b0;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pix_en = 1'b0;
    logic [CW-1:0] hcount, vcount, xcoord, ycoord, xcoord_s, ycoord_s;
    logic          coord_valid, line_start, frame_start;
    logic [FW-1:0] frame_cnt;
    logic          hsync, vsync, display_en, blank_n;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP), .COUNT_W(CW), .PIPE_DEPTH(PD),
        .SCALE_SHIFT(SS), .FRAME_W(FW)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .hcount(hcount), .vcount(vcount), .xcoord(xcoord), .ycoord(ycoord),
        .xcoord_s(xcoord_s), .ycoord_s(ycoord_s), .coord_valid(coord_valid),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt),
        .hsync(hsync), .vsync(vsync), .display_en(display_en), .blank_n(blank_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tick;
        int hc, vc, x, y, xs, ys, cv, ls, fs, fc, hs, vs, de;
    } exp_t;

    exp_t        sb[$];
    int unsigned k = 0;
    int          errors = 0;
    int          checks = 0;

    function automatic bit in_active(int hc, int vc);
        return (hc >= HSW + HB) && (hc < HSW + HB + HA) &&
               (vc >= VSW + VB) && (vc < VSW + VB + VA);
    endfunction

    // Expected outputs during a cycle that sits at tick t with the given pix_en.
    function automatic exp_t model(int unsigned t, bit pe);
        exp_t e;
        int   hc, vc, dh, dv;
        bit   act, hs_a, vs_a, de_a;
        hc = int'(t % HT);
        vc = int'((t / HT) % VT);
        act = in_active(hc, vc);
        e.tick = int'(t);
        e.hc = hc;
        e.vc = vc;
        e.cv = int'(act);
        e.x  = act ? hc - (HSW + HB) : 0;
        e.y  = act ? vc - (VSW + VB) : 0;
        e.xs = e.x / (1 << SS);
        e.ys = e.y / (1 << SS);
        e.ls = int'(pe && hc == 0);
        e.fs = int'(pe && hc == 0 && vc == 0);
        e.fc = int'((t / FT) % (1 << FW));
        hs_a = 1'b0;
        vs_a = 1'b0;
        de_a = 1'b0;
        if (t >= PD) begin
            dh = int'((t - PD) % HT);
            dv = int'(((t - PD) / HT) % VT);
            hs_a = (dh < HSW);
            vs_a = (dv < VSW);
            de_a = in_active(dh, dv);
        end
        e.hs = int'(HP ? hs_a : !hs_a);
        e.vs = int'(VP ? vs_a : !vs_a);
        e.de = int'(de_a);
        return e;
    endfunction

    task automatic chk(string name, int act, int req, int t);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s tick=%0d got=%0d expected=%0d", name, t, act, req);
        end
    endtask

    // Drive one clk of stimulus and queue what the DUT must show during it.
    task automatic step(bit pe, bit rst_n);
        @(posedge clk);
        #1;
        pix_en = pe;
        reset  = rst_n;
        if (!rst_n) k = 0;
        sb.push_back(model(k, pe));
        if (pe && rst_n) k++;
    endtask

    // Monitor: pops one record per cycle and compares away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("hcount",      int'(hcount),      e.hc, e.tick);
                chk("vcount",      int'(vcount),      e.vc, e.tick);
                chk("xcoord",      int'(xcoord),      e.x,  e.tick);
                chk("ycoord",      int'(ycoord),      e.y,  e.tick);
                chk("xcoord_s",    int'(xcoord_s),    e.xs, e.tick);
                chk("ycoord_s",    int'(ycoord_s),    e.ys, e.tick);
                chk("coord_valid", int'(coord_valid), e.cv, e.tick);
                chk("line_start",  int'(line_start),  e.ls, e.tick);
                chk("frame_start", int'(frame_start), e.fs, e.tick);
                chk("frame_cnt",   int'(frame_cnt),   e.fc, e.tick);
                chk("hsync",       int'(hsync),       e.hs, e.tick);
                chk("vsync",       int'(vsync),       e.vs, e.tick);
                chk("display_en",  int'(display_en),  e.de, e.tick);
                chk("blank_n",     int'(blank_n),     e.de, e.tick);
            end
        end
    end

    initial begin
        int target;
        target = 4 * HT + 7;

        // Reset held with random pix_en: nothing may advance.
        repeat (3) step(1'($urandom_range(0, 1)), 1'b0);

        // Random pixel enables across more than a full frame_cnt wrap.
        repeat (2000) step($urandom_range(0, 3) != 0, 1'b1);

        // Strict 1,0,1,0 enable pattern.
        for (int i = 0; i < 300; i++) step(i % 2 == 0, 1'b1);

        // Run to an active mid-frame point, then reset asynchronously there.
        for (int i = 0; i < 2 * FT && (k % FT) != target; i++) step(1'b1, 1'b1);
        chk("reach_midframe", int'(k % FT), target, int'(k));
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Counting restarts from (0,0) after release.
        repeat (400) step($urandom_range(0, 3) != 0, 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0, int'(k));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
